// File: rtl/bram_tdp_param_mem.sv
// bram_tdp_param_mem: true dual-port byte-write RAM with power-on clear FSM and per-port read-during-write modes.
// Define BRAM_OUT_REG_EN to add one output register stage per port (latency 2).
module bram_tdp_param_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 12,
    parameter int RD_MODE_A = 0,
    parameter int RD_MODE_B = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                enb,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [DATA_W/8-1:0] web,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [ADDR_W-1:0]   addrb,
    input  logic [DATA_W-1:0]   dina,
    input  logic [DATA_W-1:0]   dinb,
    output logic [DATA_W-1:0]   douta,
    output logic [DATA_W-1:0]   doutb,
    output logic                valida,
    output logic                validb,
    output logic                init_busy,
    output logic                collision
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] CLEAR = 1'b0, RUN = 1'b1;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              acc_a, acc_b, same;
    logic [DATA_W-1:0] rd_a_d, rd_b_d, douta_q, doutb_q;
    logic              valida_q, validb_q, coll_q;

    assign acc_a     = ena && !rst && state_q == RUN;
    assign acc_b     = enb && !rst && state_q == RUN;
    assign same      = addra == addrb;
    assign state_d   = (state_q == CLEAR && cnt_q == '1) ? RUN : state_q;
    assign cnt_d     = state_q == CLEAR ? cnt_q + 1'b1 : cnt_q;
    assign init_busy = rst || state_q == CLEAR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Port A is written after port B so A wins every byte both ports enable
    always_ff @(posedge clk) begin
        if (!rst && state_q == CLEAR)
            mem_q[cnt_q] <= '0;
        else
            for (int i = 0; i < NB; i++) begin
                if (acc_b && web[i]) mem_q[addrb][i*8 +: 8] <= dinb[i*8 +: 8];
                if (acc_a && wea[i]) mem_q[addra][i*8 +: 8] <= dina[i*8 +: 8];
            end
    end

    always_comb begin
        rd_a_d = mem_q[addra];
        rd_b_d = mem_q[addrb];
        for (int i = 0; i < NB; i++) begin
            if (RD_MODE_A == 1 && wea[i]) rd_a_d[i*8 +: 8] = dina[i*8 +: 8];
            if (RD_MODE_B == 1 && web[i]) rd_b_d[i*8 +: 8] = dinb[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            douta_q  <= '0;
            doutb_q  <= '0;
            valida_q <= 1'b0;
            validb_q <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            valida_q <= acc_a;
            validb_q <= acc_b;
            coll_q   <= acc_a && acc_b && same && (|wea || |web);
            if (acc_a) douta_q <= rd_a_d;
            if (acc_b) doutb_q <= rd_b_d;
        end
    end

`ifdef BRAM_OUT_REG_EN
    logic [DATA_W-1:0] douta2_q, doutb2_q;
    logic              valida2_q, validb2_q, coll2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            douta2_q  <= '0;
            doutb2_q  <= '0;
            valida2_q <= 1'b0;
            validb2_q <= 1'b0;
            coll2_q   <= 1'b0;
        end else begin
            valida2_q <= valida_q;
            validb2_q <= validb_q;
            coll2_q   <= coll_q;
            if (valida_q) douta2_q <= douta_q;
            if (validb_q) doutb2_q <= doutb_q;
        end
    end

    assign douta     = douta2_q;
    assign doutb     = doutb2_q;
    assign valida    = valida2_q;
    assign validb    = validb2_q;
    assign collision = coll2_q;
`else
    assign douta     = douta_q;
    assign doutb     = doutb_q;
    assign valida    = valida_q;
    assign validb    = validb_q;
    assign collision = coll_q;
`endif
endmodule
